// File: rtl/axi3_sram_responder.sv
// AXI3 slave backed by a word-addressed SRAM array. Independent read and write engines
// serve one read and one write burst concurrently (FIXED/INCR/WRAP, 1-16 beats, 32-bit).
module axi3_sram_responder #(
  parameter int MEM_AW   = 14,
  parameter int RD_DELAY = 0,
  parameter int B_DELAY  = 0
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int         DEPTH  = 1 << MEM_AW;
  localparam logic [3:0] RD_DLY = 4'(RD_DELAY);
  localparam logic [3:0] B_DLY  = 4'(B_DELAY);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} wstate_t;

  logic [31:0] mem [DEPTH];

  // WRAP only for legal lengths; any other WRAP length advances like INCR.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [3:0] len, input logic [1:0] burst);
    logic [31:0] step;
    logic [31:0] mask;
    step = 32'd1 << size;
    mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = (len inside {4'd1, 4'd3, 4'd7, 4'd15}) ?
                           ((addr & ~mask) | ((addr + step) & mask)) : (addr + step);
      default: next_addr = addr + step;
    endcase
  endfunction

  // ---------------- read engine ----------------
  rstate_t     rstate;
  logic [31:0] raddr;
  logic [3:0]  rlen;
  logic [2:0]  rsize;
  logic [1:0]  rburst;
  logic [3:0]  rbeat;
  logic [3:0]  rcnt;

  logic [31:0] ld_addr;
  logic [3:0]  ld_len;
  logic [2:0]  ld_size;
  logic [1:0]  ld_burst;
  logic [3:0]  ld_beat;
  logic        r_load;

  // With no read delay the first beat is loaded straight from the AR channel.
  always_comb begin
    ld_addr  = raddr;
    ld_len   = rlen;
    ld_size  = rsize;
    ld_burst = rburst;
    ld_beat  = rbeat;
    if (rstate == R_IDLE) begin
      ld_addr  = araddr;
      ld_len   = arlen;
      ld_size  = arsize;
      ld_burst = arburst;
      ld_beat  = 4'd0;
    end
    r_load = ((rstate == R_IDLE) && arvalid && (RD_DLY == 4'd0)) ||
             ((rstate == R_WAIT) && (rcnt == 4'd0)) ||
             ((rstate == R_BURST) && rvalid && rready && !rlast);
  end

  assign arready = (rstate == R_IDLE) && !reset;

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      rstate <= R_IDLE;
      raddr  <= '0;
      rlen   <= '0;
      rsize  <= '0;
      rburst <= '0;
      rbeat  <= '0;
      rcnt   <= '0;
      rid    <= '0;
      rdata  <= '0;
      rresp  <= '0;
      rlast  <= 1'b0;
      rvalid <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: if (arvalid) begin
          rid    <= arid;
          raddr  <= araddr;
          rlen   <= arlen;
          rsize  <= arsize;
          rburst <= arburst;
          rbeat  <= 4'd0;
          rresp  <= (arburst == 2'b11) ? 2'b10 : 2'b00;
          if (RD_DLY == 4'd0) begin
            rstate <= R_BURST;
          end else begin
            rcnt   <= RD_DLY - 4'd1;
            rstate <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rcnt == 4'd0) rstate <= R_BURST;
          else              rcnt   <= rcnt - 4'd1;
        end
        R_BURST: if (rvalid && rready && rlast) begin
          rvalid <= 1'b0;
          rlast  <= 1'b0;
          rstate <= R_IDLE;
        end
        default: rstate <= R_IDLE;
      endcase
      // Beat load overrides the AR latch of raddr/rbeat in the same cycle.
      if (r_load) begin
        rvalid <= 1'b1;
        rdata  <= (ld_burst == 2'b11) ? 32'd0 : mem[ld_addr[MEM_AW+1:2]];
        rlast  <= (ld_beat == ld_len);
        raddr  <= next_addr(ld_addr, ld_size, ld_len, ld_burst);
        rbeat  <= ld_beat + 4'd1;
      end
    end
  end

  // ---------------- write engine ----------------
  wstate_t     wstate;
  logic [31:0] waddr;
  logic [3:0]  wlen;
  logic [2:0]  wsize;
  logic [1:0]  wburst;
  logic [4:0]  wbeat;
  logic [3:0]  wcnt;
  logic [3:0]  wid_q;
  logic        in_len;
  logic        w_fire;

  assign awready = (wstate == W_IDLE) && !reset;
  assign wready  = (wstate == W_DATA) && !reset;
  assign in_len  = (wbeat <= {1'b0, wlen});
  assign w_fire  = (wstate == W_DATA) && wvalid && in_len && (wburst != 2'b11);

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      wstate <= W_IDLE;
      waddr  <= '0;
      wlen   <= '0;
      wsize  <= '0;
      wburst <= '0;
      wbeat  <= '0;
      wcnt   <= '0;
      wid_q  <= '0;
      bid    <= '0;
      bresp  <= '0;
      bvalid <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: if (awvalid) begin
          waddr  <= awaddr;
          wlen   <= awlen;
          wsize  <= awsize;
          wburst <= awburst;
          wid_q  <= awid;
          wbeat  <= 5'd0;
          wstate <= W_DATA;
        end
        W_DATA: if (wvalid) begin
          if (in_len) begin
            waddr <= next_addr(waddr, wsize, wlen, wburst);
            wbeat <= wbeat + 5'd1;
          end
          if (wlast) begin
            bid   <= wid_q;
            bresp <= ((wburst == 2'b11) || (wbeat != {1'b0, wlen})) ? 2'b10 : 2'b00;
            if (B_DLY == 4'd0) begin
              bvalid <= 1'b1;
              wstate <= W_RESP;
            end else begin
              wcnt   <= B_DLY - 4'd1;
              wstate <= W_WAIT;
            end
          end
        end
        W_WAIT: begin
          if (wcnt == 4'd0) begin
            bvalid <= 1'b1;
            wstate <= W_RESP;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        W_RESP: if (bready) begin
          bvalid <= 1'b0;
          wstate <= W_IDLE;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Memory is never cleared by reset; a read in the same cycle sees the old word.
  always_ff @(posedge aclk) begin
    if (w_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[waddr[MEM_AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  logic unused_sig;
  assign unused_sig = ^{wid, arlock, arcache, arprot, awlock, awcache, awprot};

endmodule

// File: tb/tb_axi3_sram_responder.sv
// Directed bench for axi3_sram_responder: single beats, stalled INCR, WRAP, strobes,
// error responses and reset in the middle of a read burst.
module tb_axi3_sram_responder;
  logic        aclk = 1'b0;
  logic        reset;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [3:0]  arlen, awlen, arcache, awcache, wstrb;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_data [16];
  logic [31:0] rd_data [16];
  logic        rd_last [16];
  logic [1:0]  rd_resp [16];
  logic [3:0]  rd_id   [16];
  logic [3:0]  b_id;
  logic [1:0]  b_resp;

  always #5 aclk = ~aclk;

  axi3_sram_responder dut (
    .aclk(aclk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    while (!arready && t < 50) begin @(negedge aclk); t++; end
    if (!arready) begin
      checks++; errors++;
      $display("FAIL ar_handshake timeout addr=%h", addr);
    end
    @(negedge aclk);
    arvalid = 1'b0;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    while (!awready && t < 50) begin @(negedge aclk); t++; end
    if (!awready) begin
      checks++; errors++;
      $display("FAIL aw_handshake timeout addr=%h", addr);
    end
    @(negedge aclk);
    awvalid = 1'b0;
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                             input logic [3:0] strb);
    int t;
    send_aw(id, addr, len, size, burst);
    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1'b1; wdata = wr_data[i]; wstrb = strb; wlast = (i == nbeats - 1); wid = id;
      t = 0;
      while (!wready && t < 50) begin @(negedge aclk); t++; end
      if (!wready) begin
        checks++; errors++;
        $display("FAIL w_handshake timeout beat=%0d", i);
      end
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < 50) begin @(negedge aclk); t++; end
    b_id = bid; b_resp = bresp;
    if (!bvalid) begin
      checks++; errors++;
      $display("FAIL b_response timeout addr=%h", addr);
    end
    @(negedge aclk);
    bready = 1'b0;
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    int n = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [31:0] held_d;
    logic held_l;
    send_ar(id, addr, len, size, burst);
    while (n <= int'(len) && cyc < 300) begin
      rready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (rvalid) begin
        if (stalled) begin
          checks++;
          if (rdata !== held_d || rlast !== held_l) begin
            errors++;
            $display("FAIL stall_stable got %h/%b need %h/%b", rdata, rlast, held_d, held_l);
          end
        end
        if (rready) begin
          rd_data[n] = rdata; rd_last[n] = rlast; rd_resp[n] = rresp; rd_id[n] = rid;
          n++; stalled = 0;
        end else begin
          stalled = 1; held_d = rdata; held_l = rlast;
        end
      end
      @(negedge aclk);
      cyc++;
    end
    rready = 1'b0;
    if (n <= int'(len)) begin
      checks++; errors++;
      $display("FAIL read_beats got %0d need %0d", n, int'(len) + 1);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge aclk);
    checks++;
    if ({arready, awready, wready, rvalid, bvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b need 00000", {arready, awready, wready, rvalid, bvalid});
    end
    reset = 1'b0;
    @(negedge aclk);
    checks++;
    if ({arready, awready, rvalid, bvalid} !== 4'b1100) begin
      errors++;
      $display("FAIL post_reset got %b need 1100", {arready, awready, rvalid, bvalid});
    end
  endtask

  task automatic test_single;
    wr_data[0] = 32'hDEADBEEF;
    write_burst(4'd5, 32'h100, 4'd0, 3'd2, 2'b01, 1, 4'hF);
    checks++;
    if (b_id !== 4'd5 || b_resp !== 2'b00) begin
      errors++;
      $display("FAIL single_b got id=%h resp=%b need id=5 resp=00", b_id, b_resp);
    end
    read_burst(4'd3, 32'h100, 4'd0, 3'd2, 2'b01, 1'b0);
    checks++;
    if (rd_data[0] !== 32'hDEADBEEF || rd_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_r got %h/%b need deadbeef/1", rd_data[0], rd_last[0]);
    end
    checks++;
    if (rd_id[0] !== 4'd3 || rd_resp[0] !== 2'b00) begin
      errors++;
      $display("FAIL single_rid got id=%h resp=%b need id=3 resp=00", rd_id[0], rd_resp[0]);
    end
  endtask

  task automatic test_incr_stall;
    for (int i = 0; i < 8; i++) wr_data[i] = 32'hC0DE0000 | 32'(i * 17);
    write_burst(4'd1, 32'h40, 4'd7, 3'd2, 2'b01, 8, 4'hF);
    checks++;
    if (b_resp !== 2'b00) begin
      errors++;
      $display("FAIL incr_b got %b need 00", b_resp);
    end
    read_burst(4'd2, 32'h40, 4'd7, 3'd2, 2'b01, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_data[i] !== (32'hC0DE0000 | 32'(i * 17)) || rd_last[i] !== (i == 7)) begin
        errors++;
        $display("FAIL incr_beat%0d got %h/%b need %h/%b", i, rd_data[i], rd_last[i],
                 32'hC0DE0000 | 32'(i * 17), (i == 7));
      end
    end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_r [4];
    logic [31:0] exp_w [4];
    wr_data[0] = 32'hB0B0B0B0; wr_data[1] = 32'hB1B1B1B1;
    wr_data[2] = 32'hB2B2B2B2; wr_data[3] = 32'hB3B3B3B3;
    write_burst(4'd0, 32'h10, 4'd3, 3'd2, 2'b01, 4, 4'hF);
    exp_r[0] = 32'hB2B2B2B2; exp_r[1] = 32'hB3B3B3B3;
    exp_r[2] = 32'hB0B0B0B0; exp_r[3] = 32'hB1B1B1B1;
    read_burst(4'd0, 32'h18, 4'd3, 3'd2, 2'b10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== exp_r[i]) begin
        errors++;
        $display("FAIL wrap_read%0d got %h need %h", i, rd_data[i], exp_r[i]);
      end
    end
    wr_data[0] = 32'hA0A0A0A0; wr_data[1] = 32'hA1A1A1A1;
    wr_data[2] = 32'hA2A2A2A2; wr_data[3] = 32'hA3A3A3A3;
    write_burst(4'd0, 32'h18, 4'd3, 3'd2, 2'b10, 4, 4'hF);
    exp_w[0] = 32'hA2A2A2A2; exp_w[1] = 32'hA3A3A3A3;
    exp_w[2] = 32'hA0A0A0A0; exp_w[3] = 32'hA1A1A1A1;
    read_burst(4'd0, 32'h10, 4'd3, 3'd2, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL wrap_write%0d got %h need %h", i, rd_data[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_strobe;
    wr_data[0] = 32'h11223344;
    write_burst(4'd2, 32'h200, 4'd0, 3'd2, 2'b01, 1, 4'hF);
    wr_data[0] = 32'hAABBCCDD;
    write_burst(4'd2, 32'h200, 4'd0, 3'd2, 2'b01, 1, 4'b0101);
    read_burst(4'd2, 32'h200, 4'd0, 3'd2, 2'b01, 1'b0);
    checks++;
    if (rd_data[0] !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL strobe got %h need 11bb33dd", rd_data[0]);
    end
  endtask

  task automatic test_errors;
    wr_data[0] = 32'h1; wr_data[1] = 32'h2;
    write_burst(4'd7, 32'h300, 4'd3, 3'd2, 2'b01, 2, 4'hF);
    checks++;
    if (b_resp !== 2'b10 || b_id !== 4'd7) begin
      errors++;
      $display("FAIL early_wlast got id=%h resp=%b need id=7 resp=10", b_id, b_resp);
    end
    read_burst(4'd9, 32'h100, 4'd1, 3'd2, 2'b11, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_resp[i] !== 2'b10 || rd_data[i] !== 32'd0 || rd_last[i] !== (i == 1)) begin
        errors++;
        $display("FAIL rsvd_burst%0d got resp=%b data=%h last=%b need 10/0/%b",
                 i, rd_resp[i], rd_data[i], rd_last[i], (i == 1));
      end
    end
    wr_data[0] = 32'h55;
    write_burst(4'd0, 32'h404, 4'd0, 3'd2, 2'b01, 1, 4'hF);
    wr_data[0] = 32'h1; wr_data[1] = 32'h2; wr_data[2] = 32'h3;
    write_burst(4'd0, 32'h400, 4'd2, 3'd2, 2'b00, 3, 4'hF);
    read_burst(4'd0, 32'h400, 4'd1, 3'd2, 2'b01, 1'b0);
    checks++;
    if (rd_data[0] !== 32'h3 || rd_data[1] !== 32'h55) begin
      errors++;
      $display("FAIL fixed_burst got %h,%h need 3,55", rd_data[0], rd_data[1]);
    end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    int t = 0;
    for (int i = 0; i < 16; i++) wr_data[i] = 32'h80000000 + 32'(i);
    write_burst(4'd4, 32'h800, 4'd15, 3'd2, 2'b01, 16, 4'hF);
    send_ar(4'd4, 32'h800, 4'd15, 3'd2, 2'b01);
    rready = 1'b1;
    while (n < 4 && t < 100) begin
      if (rvalid) n++;
      @(negedge aclk);
      t++;
    end
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h80000004) begin
      errors++;
      $display("FAIL beat5 got v=%b d=%h need v=1 d=80000004", rvalid, rdata);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b0 || rlast !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got rvalid=%b arready=%b rlast=%b need 0/0/0",
               rvalid, arready, rlast);
    end
    rready = 1'b0;
    repeat (2) @(negedge aclk);
    reset = 1'b0;
    @(negedge aclk);
    checks++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset got arready=%b rvalid=%b need 1/0", arready, rvalid);
    end
    read_burst(4'd6, 32'h808, 4'd1, 3'd2, 2'b01, 1'b0);
    checks++;
    if (rd_data[0] !== 32'h80000002 || rd_data[1] !== 32'h80000003 || rd_last[1] !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_read got %h,%h last=%b need 80000002,80000003 last=1",
               rd_data[0], rd_data[1], rd_last[1]);
    end
  endtask

  initial begin
    reset = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    arlock = '0; arcache = '0; arprot = '0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    awlock = '0; awcache = '0; awprot = '0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    @(negedge aclk);
    test_reset;
    test_single;
    test_incr_stall;
    test_wrap;
    test_strobe;
    test_errors;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
